// File: rtl/d1s_sweep_ctrl.sv
// Sweep sequencer that exercises every input vector of the d1s4439 pattern
// detector and checks its output, reporting mismatch count, first failure and verdict.
module d1s_sweep_ctrl #(
   parameter int               WIDTH  = 3,
   parameter logic [WIDTH-1:0] MATCH  = 3'b110,
   parameter int               SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [WIDTH-1:0] pattern,
   input  logic             dut_d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   err_count,
   output logic [WIDTH-1:0] first_fail,
   output logic             fail_valid
);

   localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
   localparam logic [WIDTH-1:0] PAT_LAST = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] pattern_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [WIDTH:0]   err_count_q;
   logic [WIDTH-1:0] first_fail_q;
   logic             fail_valid_q;

   logic             mismatch;
   logic [WIDTH:0]   err_count_d;

   // The verdict is taken on the edge entering DONE, so it must include the last vector's result.
   always_comb begin
      mismatch    = (dut_d != (pattern_q == MATCH));
      err_count_d = err_count_q + {{WIDTH{1'b0}}, mismatch};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         pattern_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_count_q  <= '0;
         first_fail_q <= '0;
         fail_valid_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q      <= S_SETTLE;
                  busy_q       <= 1'b1;
                  cnt_q        <= '0;
                  pattern_q    <= '0;
                  pass_q       <= 1'b0;
                  err_count_q  <= '0;
                  first_fail_q <= '0;
                  fail_valid_q <= 1'b0;
               end
            end
            S_SETTLE: begin
               if (abort) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  pattern_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST) begin
                     state_q <= S_SAMPLE;
                  end
               end
            end
            S_SAMPLE: begin
               if (abort) begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
                  pattern_q <= '0;
               end else begin
                  err_count_q <= err_count_d;
                  if (mismatch && !fail_valid_q) begin
                     first_fail_q <= pattern_q;
                     fail_valid_q <= 1'b1;
                  end
                  if (pattern_q == PAT_LAST) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_count_d == '0);
                  end else begin
                     state_q   <= S_SETTLE;
                     cnt_q     <= '0;
                     pattern_q <= pattern_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q   <= S_IDLE;
               pattern_q <= '0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pattern    = pattern_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_count_q;
   assign first_fail = first_fail_q;
   assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_d1s_sweep_ctrl.sv
// Directed bench for d1s_sweep_ctrl: golden, stuck-at-0 and inverted detector models,
// ignored restarts, abort and mid-sweep reset, with cycle-accurate expectations.
module tb_d1s_sweep_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [2:0] pattern;
   logic       dut_d;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] err_count;
   logic [2:0] first_fail;
   logic       fail_valid;

   int         mode;
   int         nChecks;
   int         nFails;

   d1s_sweep_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .pattern    (pattern),
      .dut_d      (dut_d),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail),
      .fail_valid (fail_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Detector models: 0 = golden (d only for 110), 1 = stuck at 0, 2 = inverted golden.
   always_comb begin
      case (mode)
         1:       dut_d = 1'b0;
         2:       dut_d = (pattern != 3'b110);
         default: dut_d = (pattern == 3'b110);
      endcase
   end

   // Relative cycle r counts from the start edge (cycle 0); each vector lasts 3 cycles.
   function automatic logic expBusy(input int r);
      return (r >= 1) && (r <= 24);
   endfunction

   function automatic logic [2:0] expPattern(input int r);
      if ((r >= 1) && (r <= 24)) return 3'((r - 1) / 3);
      return 3'd0;
   endfunction

   task automatic test_reset;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      repeat (2) @(negedge clk);
      nChecks += 7;
      if (pattern !== 3'd0) begin nFails++; $display("[TB] FAIL reset_pattern got %0d want 0", pattern); end
      if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", done); end
      if (pass !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pass got %b want 0", pass); end
      if (err_count !== 4'd0) begin nFails++; $display("[TB] FAIL reset_err got %0d want 0", err_count); end
      if (first_fail !== 3'd0) begin nFails++; $display("[TB] FAIL reset_ff got %0d want 0", first_fail); end
      if (fail_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_fv got %b want 0", fail_valid); end
      rst = 1'b0;
   endtask

   // Full sweep with a given detector model, then the verdict in the done cycle.
   task automatic test_sweep(input string name, input int m, input logic [3:0] wantErr,
                             input logic [2:0] wantFf, input logic wantFv, input logic wantPass);
      mode = m;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         start = 1'b0;
         nChecks += 2;
         if (busy !== expBusy(c)) begin nFails++; $display("[TB] FAIL %s_busy c=%0d got %b want %b", name, c, busy, expBusy(c)); end
         if (done !== (c == 25)) begin nFails++; $display("[TB] FAIL %s_done c=%0d got %b want %b", name, c, done, (c == 25)); end
         if (expBusy(c)) begin
            nChecks++;
            if (pattern !== expPattern(c)) begin nFails++; $display("[TB] FAIL %s_pattern c=%0d got %0d want %0d", name, c, pattern, expPattern(c)); end
         end
         if (c >= 25) begin
            nChecks += 3;
            if (pass !== wantPass) begin nFails++; $display("[TB] FAIL %s_pass c=%0d got %b want %b", name, c, pass, wantPass); end
            if (err_count !== wantErr) begin nFails++; $display("[TB] FAIL %s_err c=%0d got %0d want %0d", name, c, err_count, wantErr); end
            if (fail_valid !== wantFv) begin nFails++; $display("[TB] FAIL %s_fv c=%0d got %b want %b", name, c, fail_valid, wantFv); end
            if (wantFv) begin
               nChecks++;
               if (first_fail !== wantFf) begin nFails++; $display("[TB] FAIL %s_ff got %0d want %0d", name, first_fail, wantFf); end
            end
         end
      end
   endtask

   task automatic test_start_ignored;
      int doneCount;
      doneCount = 0;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = (c == 5) || (c == 25);
         if (done === 1'b1) doneCount++;
         nChecks++;
         if (busy !== expBusy(c)) begin nFails++; $display("[TB] FAIL restart_busy c=%0d got %b want %b", c, busy, expBusy(c)); end
         if (expBusy(c)) begin
            nChecks++;
            if (pattern !== expPattern(c)) begin nFails++; $display("[TB] FAIL restart_pattern c=%0d got %0d want %0d", c, pattern, expPattern(c)); end
         end
      end
      start = 1'b0;
      nChecks++;
      if (doneCount !== 1) begin nFails++; $display("[TB] FAIL restart_done_count got %0d want 1", doneCount); end
   endtask

   task automatic test_abort;
      logic sawDone;
      sawDone = 1'b0;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (c == 10);
         if (done === 1'b1) sawDone = 1'b1;
         if (c == 10) begin
            nChecks++;
            if (pattern !== 3'd3) begin nFails++; $display("[TB] FAIL abort_pre_pattern got %0d want 3", pattern); end
         end
         if (c >= 11) begin
            nChecks += 3;
            if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy c=%0d got %b want 0", c, busy); end
            if (pattern !== 3'd0) begin nFails++; $display("[TB] FAIL abort_pattern c=%0d got %0d want 0", c, pattern); end
            if (pass !== 1'b0) begin nFails++; $display("[TB] FAIL abort_pass c=%0d got %b want 0", c, pass); end
         end
      end
      abort = 1'b0;
      nChecks++;
      if (sawDone !== 1'b0) begin nFails++; $display("[TB] FAIL abort_done got %b want 0", sawDone); end
      test_sweep("after_abort", 0, 4'd0, 3'd0, 1'b0, 1'b1);
   endtask

   // Reset in cycle 14 with start held: outputs clear, then sweep restarts and re-arms after DONE.
   task automatic test_back_to_back;
      mode = 0;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 42; c++) begin
         @(negedge clk);
         rst = (c == 14);
         if (c == 15) begin
            nChecks += 7;
            if (pattern !== 3'd0) begin nFails++; $display("[TB] FAIL rst_mid_pattern got %0d want 0", pattern); end
            if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy); end
            if (done !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_done got %b want 0", done); end
            if (pass !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_pass got %b want 0", pass); end
            if (err_count !== 4'd0) begin nFails++; $display("[TB] FAIL rst_mid_err got %0d want 0", err_count); end
            if (first_fail !== 3'd0) begin nFails++; $display("[TB] FAIL rst_mid_ff got %0d want 0", first_fail); end
            if (fail_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_fv got %b want 0", fail_valid); end
         end else if (c < 14) begin
            nChecks++;
            if (pattern !== expPattern(c)) begin nFails++; $display("[TB] FAIL rst_pre_pattern c=%0d got %0d want %0d", c, pattern, expPattern(c)); end
         end else if (c >= 16 && c <= 41) begin
            nChecks += 2;
            if (busy !== expBusy(c - 15)) begin nFails++; $display("[TB] FAIL rst_re_busy c=%0d got %b want %b", c, busy, expBusy(c - 15)); end
            if (done !== (c == 40)) begin nFails++; $display("[TB] FAIL rst_re_done c=%0d got %b want %b", c, done, (c == 40)); end
            if (expBusy(c - 15)) begin
               nChecks++;
               if (pattern !== expPattern(c - 15)) begin nFails++; $display("[TB] FAIL rst_re_pattern c=%0d got %0d want %0d", c, pattern, expPattern(c - 15)); end
            end
         end else if (c == 42) begin
            nChecks += 2;
            if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL held_start_busy got %b want 1", busy); end
            if (pattern !== 3'd0) begin nFails++; $display("[TB] FAIL held_start_pattern got %0d want 0", pattern); end
         end
      end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      mode    = 0;
      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      test_reset();
      test_sweep("golden", 0, 4'd0, 3'd0, 1'b0, 1'b1);
      test_sweep("stuck0", 1, 4'd1, 3'b110, 1'b1, 1'b0);
      test_sweep("inverted", 2, 4'd8, 3'b000, 1'b1, 1'b0);
      test_start_ignored();
      test_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
